// File: rtl/char_pulse_rx.sv
// Character pulse receiver: synchronizes an asynchronous pulse line, measures the
// high width of each pulse and enforces the width window and the minimum low gap between pulses.
module char_pulse_rx #(
  parameter int NOMINAL = 65,
  parameter int TOL     = 2,
  parameter int GAP_MIN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [8:0]  width,
  output logic        busy,
  output logic [15:0] char_count
);

  localparam int GAP_W = (GAP_MIN < 2) ? 1 : $clog2(GAP_MIN + 1);

  localparam logic [8:0]       CNT_MAX   = '1;
  localparam logic [8:0]       SHORT_LIM = 9'(NOMINAL - TOL);
  localparam logic [8:0]       LONG_LIM  = 9'(NOMINAL + TOL);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_MIN - 1);
  localparam logic [15:0]      CHAR_MAX  = '1;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_GAP   = 2'b11;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_HIGH,
    ST_LONG,
    ST_GAP
  } state_e;

  logic             sync1_q;
  logic             s_q;
  logic [1:0]       prime_q;

  state_e           state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [8:0]       width_q, width_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [15:0]      char_count_q, char_count_d;

  // prime_q marks when s_q carries a real sample of in rather than the reset
  // value, so ARM cannot mistake a line held high through reset for a low level.
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of the others regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      prime_q <= 2'b00;
    end else begin
      sync1_q <= in;
      s_q     <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // NOTE: every output of this block gets a default first; a path that leaves a
  // signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    width_d = width_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;

    unique case (state_q)
      ST_ARM: begin
        if (!s_q && prime_q[1]) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (s_q) begin
          state_d = ST_HIGH;
          cnt_d   = 9'd1;
        end
      end

      ST_HIGH: begin
        if (s_q) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == LONG_LIM) state_d = ST_LONG;
        end else begin
          width_d = cnt_q;
          if (cnt_q >= SHORT_LIM) begin
            valid_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_SHORT;
          end
          state_d = ST_GAP;
          gap_d   = GAP_W'(1);
        end
      end

      ST_LONG: begin
        if (s_q) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 9'd1;
        end else begin
          width_d = cnt_q;
          err_d   = 1'b1;
          code_d  = ERR_LONG;
          state_d = ST_GAP;
          gap_d   = GAP_W'(1);
        end
      end

      ST_GAP: begin
        // A rising edge inside the gap is rejected unmeasured; ARM waits for the line to drop.
        if (s_q) begin
          err_d   = 1'b1;
          code_d  = ERR_GAP;
          state_d = ST_ARM;
        end else begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_q >= GAP_LAST) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_ARM;
    endcase
  end

  always_comb begin
    char_count_d = char_count_q;
    if (valid_d && (char_count_q != CHAR_MAX)) char_count_d = char_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ARM;
      cnt_q        <= '0;
      gap_q        <= '0;
      width_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= ERR_NONE;
      char_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      width_q      <= width_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      code_q       <= code_d;
      char_count_q <= char_count_d;
    end
  end

  assign valid      = valid_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign width      = width_q;
  assign char_count = char_count_q;
  assign busy       = (state_q == ST_HIGH) || (state_q == ST_LONG) || (state_q == ST_GAP);

endmodule

// File: doc/char_pulse_rx.md
CHAR_PULSE_RX -- requirements
Module: char_pulse_rx

Interface
REQ-001 SHALL have parameter NOMINAL, default 65, the expected high width of a character pulse in clk cycles.
REQ-002 SHALL have parameter TOL, default 2, the allowed ± deviation from NOMINAL in cycles.
REQ-003 SHALL have parameter GAP_MIN, default 8, the minimum low cycles required between pulses.
REQ-004 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in  input  1  asynchronous character pulse line from the transmitter.
REQ-007 SHALL have port valid  output  1  one-cycle strobe when a pulse of legal width completes.
REQ-008 SHALL have port err  output  1  one-cycle strobe when a pulse or gap is illegal.
REQ-009 SHALL have port err_code  output  2  error cause: 01 SHORT, 10 LONG, 11 GAP; 00 when err=0.
REQ-010 SHALL have port width  output  9  measured high width of the last completed pulse, held until the next completion.
REQ-011 SHALL have port busy  output  1  high while in HIGH, LONG or GAP state.
REQ-012 SHALL have port char_count  output  16  count of valid strobes, saturating at 16'hFFFF.

Function
REQ-013 SHALL pass in through a 2-flop synchronizer; s denotes the second flop output, and all further logic uses s only.
REQ-014 SHALL implement states ARM, IDLE, HIGH, LONG and GAP, each encoded as a register.
REQ-015 ARM: s=0 -> IDLE; otherwise stay. This prevents a line high at reset release from counting as a pulse.
REQ-016 IDLE: s=1 -> HIGH, with cnt<=1; otherwise stay.
REQ-017 HIGH with s=1: cnt<=cnt+1; when cnt = NOMINAL+TOL and s=1, go to LONG.
REQ-018 HIGH with s=0: register width<=cnt; if cnt >= NOMINAL-TOL, pulse valid; else pulse err with code SHORT; then -> GAP with gap counter <=1.
REQ-019 LONG with s=1: cnt keeps incrementing, saturating at 511, with no strobe.
REQ-020 LONG with s=0: width<=cnt; pulse err with code LONG; -> GAP with gap counter <=1.
REQ-021 GAP with s=0: gap counter increments; on reaching GAP_MIN -> IDLE.
REQ-022 GAP with s=1: pulse err with code GAP; -> ARM. The offending pulse SHALL NOT be measured or counted.
REQ-023 valid and err SHALL be registered, mutually exclusive, and each high for exactly one cycle per event.
REQ-024 Latency: the strobe SHALL assert on the 3rd rising edge after the first edge that samples in low (2 synchronizer edges + 1 evaluation edge).
REQ-025 For a clean pulse, width SHALL equal the number of edges that sampled in high.
REQ-026 char_count SHALL increment in the same cycle valid is high; it SHALL NOT wrap.
REQ-027 busy SHALL be combinational from the state register.
REQ-028 Pulses of one cycle SHALL be measured normally (width=1, SHORT); no glitch filter.

Reset
REQ-029 reset SHALL force synchronizer flops to 0 and state to ARM, and clear cnt, gap counter, valid, err, err_code, width and char_count.
REQ-030 reset asserted mid-pulse SHALL abort the measurement with no strobe; measurement SHALL resume only after s is seen low.
REQ-031 reset SHALL take priority over all other events in the same cycle.

Verification
REQ-032 Idle line, then in high for 65 cycles -> single valid, width=65, char_count=1, err=0.
REQ-033 in high for 62 cycles -> err=1, err_code=01, width=62, char_count unchanged.
REQ-034 in high for 70 cycles -> LONG entered after 67 high cycles; err=1, err_code=10, width=70 on release.
REQ-035 65-cycle pulse, low for 4 cycles, then high again -> valid for the first pulse, then err=1, err_code=11; state ARM until in goes low.
REQ-036 reset pulsed at cycle 30 of a 65-cycle pulse with in kept high -> no strobe; the next clean 65-cycle pulse -> valid, char_count=1.
REQ-037 Back-to-back legal pulses separated by exactly GAP_MIN low cycles -> both are valid; char_count increments by 2.
